macc_accum: RTL and testbench
=============================

// Module: macc_accum
// PURPOSE
//  Signed multiply-accumulate stage directly upstream of the ReLU/clip output stage.
//  - Consumes a stream of signed 8-bit activation/weight pairs.
//  - Accumulates KERNEL_LEN products plus a bias into one window sum.
//  - Presents the sum as a 16-bit signed result whose val_out feeds ReLU_out.val_in.
//  - One window (e.g. 3x3 kernel = 9 pairs) yields one output.
// PARAMETERS
//  DATA_W      8   width of signed activation and weight inputs
//  ACC_W       20  internal signed accumulator width; must hold KERNEL_LEN products + bias
//  OUT_W       16  width of signed result val_out
//  KERNEL_LEN  9   products per window, >= 1
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous reset, active low
//  bias       in   OUT_W    signed bias, sampled on the first accepted pair of a window
//  in_valid   in   1        act/wgt valid
//  in_ready   out  1        stage can accept a pair (combinational: state != HOLD)
//  act        in   DATA_W   signed activation
//  wgt        in   DATA_W   signed weight
//  out_valid  out  1        val_out holds a complete window sum
//  out_ready  in   1        downstream accepts val_out
//  val_out    out  OUT_W    signed window result (registered)
//  busy       out  1        window in progress (state == ACCUM)
// BEHAVIOUR
//  - Reset (rst_n low, async):
//      state=IDLE, cnt=0, acc=0, val_out=0, out_valid=0, busy=0, in_ready=1.
//      Flops are held, so inputs are ignored.
//      Reset mid-window discards the partial sum; next window starts from cnt=0.
//  - Handshakes:
//      Accept when in_valid && in_ready.
//      Output transfer when out_valid && out_ready.
//      in_valid bubbles between pairs are allowed and do not alter the result.
//  - Product: prod = act*wgt, signed, 2*DATA_W bits (-128*-128 = 16384 fits).
//  - Accumulation:
//      First accept (cnt==0): acc <= sext(bias) + sext(prod).
//      Later accepts: acc <= acc + sext(prod).
//  - FSM:
//      IDLE  --accept, KERNEL_LEN>1-->  ACCUM, cnt=1
//      IDLE  --accept, KERNEL_LEN==1--> HOLD
//      ACCUM --accept, cnt==KERNEL_LEN-1--> HOLD, cnt=0
//      ACCUM --accept, otherwise--> ACCUM, cnt+1
//      HOLD  --out_ready--> IDLE
//  - Latency:
//      out_valid and val_out are registered on the same edge that enters HOLD,
//      i.e. valid from the cycle after the last pair is accepted.
//  - HOLD:
//      in_ready=0; in_valid is ignored.
//      val_out and out_valid stay stable until out_ready.
//      out_valid clears on the transfer edge; in_ready rises the cycle after (no bypass).
//  - Overflow: the accumulator never wraps for default parameters
//      (9*16384 + 32767 < 2^19). Output narrowing is set by CONFIGURATION.
// CONFIGURATION
//  MACC_SAT_EN defined:
//      val_out = acc clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1], i.e. 0x8000..0x7FFF.
//  MACC_SAT_EN undefined:
//      val_out = acc[OUT_W-1:0] (two's-complement wrap). Clamp logic is absent.
// STRUCTURE
//  - Package macc_pkg holds:
//      state enum {IDLE, ACCUM, HOLD};
//      DATA_W/ACC_W/OUT_W defaults;
//      OUT_MAX/OUT_MIN constants;
//      the saturate function.
//  - Sub-module macc_mult: signed DATA_W x DATA_W -> 2*DATA_W combinational multiplier.
//  - The FSM, counter, accumulator and output register live in macc_accum.
// TESTING
//  1. bias=0, 9 pairs act=1 wgt=1, out_ready=1
//       -> val_out=9, out_valid 1 cycle after 9th accept, high 1 cycle.
//  2. bias=0, 9 pairs act=-128 wgt=-128 (sum 147456)
//       -> SAT_EN: 0x7FFF; no SAT_EN: 0x4000.
//  3. bias=0, 9 pairs act=-128 wgt=127 (sum -146304)
//       -> SAT_EN: 0x8000.
//     bias=-5, 9 pairs act=2 wgt=-3 -> val_out=-59 (0xFFC5).
//  4. out_ready=0 for 5 cycles after out_valid, in_valid=1 throughout
//       -> val_out stable, in_ready=0, no pair consumed;
//          next window's result is independent.
//  5. 9 pairs act=k wgt=1 (k=1..9) with random in_valid gaps
//       -> val_out=45.
//  6. rst_n pulsed low after 4 accepted pairs
//       -> all outputs 0 immediately;
//          next window of 9 x (1,1) with bias=0 -> val_out=9.

Source files
------------

// File: rtl/macc_pkg.sv
// Shared types, default widths and output narrowing helper for the MAC window stage.
// Optional build macro MACC_SAT_EN selects saturating narrowing in macc_accum.
package macc_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int ACC_W_DEF      = 20;
  localparam int OUT_W_DEF      = 16;
  localparam int KERNEL_LEN_DEF = 9;

  localparam logic [OUT_W_DEF-1:0] OUT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic [OUT_W_DEF-1:0] OUT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Clamp a signed value into the range of a w-bit two's-complement word.
  function automatic longint saturate(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -(longint'(1) <<< (w - 1));
    if (v > hi) begin
      return hi;
    end
    if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/macc_accum_if.sv
// Stream-in / result-out handshake bundle between the MAC stage and its neighbours.
// master drives pairs and accepts results; slave is the MAC stage itself.
interface macc_accum_if
  import macc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OUT_W  = OUT_W_DEF
);

  logic signed [OUT_W-1:0]  bias;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] act;
  logic signed [DATA_W-1:0] wgt;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  val_out;
  logic                     busy;

  modport master (
    output bias, in_valid, act, wgt, out_ready,
    input  in_ready, out_valid, val_out, busy
  );

  modport slave (
    input  bias, in_valid, act, wgt, out_ready,
    output in_ready, out_valid, val_out, busy
  );

endinterface

// File: rtl/macc_mult.sv
// Combinational signed DATA_W x DATA_W multiplier producing a full 2*DATA_W product.
module macc_mult
  import macc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [DATA_W-1:0]   i_a,
  input  logic signed [DATA_W-1:0]   i_b,
  output logic signed [2*DATA_W-1:0] o_p
);

  assign o_p = i_a * i_b;

endmodule

// File: rtl/macc_accum.sv
// Signed multiply-accumulate over KERNEL_LEN pairs plus bias; one registered result per window.
// Define MACC_SAT_EN to clamp the result to OUT_W bits instead of wrapping.
module macc_accum
  import macc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int OUT_W      = OUT_W_DEF,
  parameter int KERNEL_LEN = KERNEL_LEN_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  macc_accum_if.slave s
);

  localparam int CNT_W = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [OUT_W-1:0]   r_val_out;
  logic                      r_out_valid;
  logic                      r_busy;

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_bias_ext;
  logic signed [ACC_W-1:0]    w_acc_next;
  logic signed [OUT_W-1:0]    w_val_next;
  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_last;

  macc_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .i_a (s.act),
    .i_b (s.wgt),
    .o_p (w_prod)
  );

  assign w_in_ready = (r_state != HOLD);
  assign w_accept   = s.in_valid && w_in_ready;
  assign w_last     = (r_cnt == CNT_W'(KERNEL_LEN - 1));

  assign w_prod_ext = {{(ACC_W - 2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  assign w_bias_ext = {{(ACC_W - OUT_W){s.bias[OUT_W-1]}}, s.bias};

  // The first pair of a window seeds the sum with bias instead of the stale accumulator.
  assign w_acc_next = ((r_cnt == '0) ? w_bias_ext : r_acc) + w_prod_ext;

`ifdef MACC_SAT_EN
  assign w_val_next = OUT_W'(saturate(longint'(w_acc_next), OUT_W));
`else
  assign w_val_next = w_acc_next[OUT_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_val_out   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_accept) begin
            r_acc <= w_acc_next;
            if (w_last) begin
              // Result is registered on the same edge that enters HOLD.
              r_state     <= HOLD;
              r_cnt       <= '0;
              r_val_out   <= w_val_next;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state <= ACCUM;
              r_cnt   <= r_cnt + CNT_W'(1);
              r_busy  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (s.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign s.in_ready  = w_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.val_out   = r_val_out;
  assign s.busy      = r_busy;

endmodule

// File: tb/tb_macc_accum.sv
// Scoreboard bench for macc_accum: expected window sums are queued at stimulus time
// and compared when the result handshake fires.
module tb_macc_accum;

  logic clk;
  logic rst_n;

  int n_total = 0;
  int n_bad   = 0;

  logic [15:0] exp_q[$];
  int pa[9];
  int pw[9];

  macc_accum_if u_if ();

  macc_accum u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] narrow(input int sum);
    logic [31:0] v;
    v = sum;
`ifdef MACC_SAT_EN
    if (sum > 32767) return 16'h7FFF;
    if (sum < -32768) return 16'h8000;
`endif
    return v[15:0];
  endfunction

  // Called at a negedge; returns at the negedge after the pair was accepted.
  task automatic send_pair(input int a, input int w);
    int t;
    u_if.in_valid = 1'b1;
    u_if.act      = 8'(a);
    u_if.wgt      = 8'(w);
    t = 0;
    while (!u_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_to", {31'd0, u_if.in_ready}, 32'd1);
    @(negedge clk);
    u_if.in_valid = 1'b0;
    $display("pair act=%0d wgt=%0d accepted t=%0t", a, w, $time);
  endtask

  task automatic run_window(input int b, input bit gaps, input bit push, input int n,
                            input int bias_after);
    int sum;
    sum = b;
    for (int i = 0; i < n; i++) sum += pa[i] * pw[i];
    if (push) exp_q.push_back(narrow(sum));
    u_if.bias = 16'(b);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pair(pa[i], pw[i]);
      if (i == 0) u_if.bias = 16'(bias_after);
    end
  endtask

  // Result monitor: samples shortly after the negedge, once inputs have settled.
  always begin
    logic [15:0] e;
    @(negedge clk);
    #1;
    if (rst_n && u_if.out_valid && u_if.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("val_out", {16'd0, u_if.val_out}, {16'd0, e});
        $display("result val_out=%0h exp=%0h t=%0t", u_if.val_out, e, $time);
      end
    end
  end

  initial begin
    int t;
    rst_n          = 1'b1;
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    u_if.act       = '0;
    u_if.wgt       = '0;
    u_if.bias      = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    chk("rst_val_out", {16'd0, u_if.val_out}, 32'd0);
    chk("rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: nine (1,1) pairs with latency and single-cycle valid checks
    exp_q.push_back(16'd9);
    u_if.bias = '0;
    for (int i = 0; i < 8; i++) send_pair(1, 1);
    chk("t1_busy_mid", {31'd0, u_if.busy}, 32'd1);
    chk("t1_ov_early", {31'd0, u_if.out_valid}, 32'd0);
    send_pair(1, 1);
    chk("t1_ov_set", {31'd0, u_if.out_valid}, 32'd1);
    chk("t1_busy_done", {31'd0, u_if.busy}, 32'd0);
    chk("t1_in_ready_hold", {31'd0, u_if.in_ready}, 32'd0);
    @(negedge clk);
    chk("t1_ov_clear", {31'd0, u_if.out_valid}, 32'd0);
    chk("t1_in_ready_back", {31'd0, u_if.in_ready}, 32'd1);

    // 2: positive overflow of the output word
    for (int i = 0; i < 9; i++) begin pa[i] = -128; pw[i] = -128; end
    run_window(0, 1'b0, 1'b1, 9, 0);
    // 3: negative overflow, then a small negative sum with bias changed mid-window
    for (int i = 0; i < 9; i++) begin pa[i] = -128; pw[i] = 127; end
    run_window(0, 1'b0, 1'b1, 9, 0);
    for (int i = 0; i < 9; i++) begin pa[i] = 2; pw[i] = -3; end
    run_window(-5, 1'b0, 1'b1, 9, 1234);

    // 4: downstream stall with in_valid held high
    @(negedge clk);
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin pa[i] = i + 3; pw[i] = 2; end
    run_window(7, 1'b0, 1'b1, 9, 7);
    u_if.in_valid = 1'b1;
    u_if.act      = 8'd100;
    u_if.wgt      = 8'd100;
    for (int c = 0; c < 5; c++) begin
      chk("t4_ov_hold", {31'd0, u_if.out_valid}, 32'd1);
      chk("t4_in_ready_hold", {31'd0, u_if.in_ready}, 32'd0);
      chk("t4_val_stable", {16'd0, u_if.val_out}, {16'd0, narrow(7 + 2 * 63)});
      chk("t4_busy_hold", {31'd0, u_if.busy}, 32'd0);
      @(negedge clk);
    end
    u_if.out_ready = 1'b1;
    u_if.in_valid  = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin pa[i] = i + 1; pw[i] = -1; end
    run_window(3, 1'b0, 1'b1, 9, 3);

    // 5: k*1 for k=1..9 with random bubbles
    for (int i = 0; i < 9; i++) begin pa[i] = i + 1; pw[i] = 1; end
    run_window(0, 1'b1, 1'b1, 9, 0);

    // 6: reset after four accepted pairs
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin pa[i] = 1; pw[i] = 1; end
    run_window(0, 1'b0, 1'b0, 4, 0);
    chk("t6_busy_pre", {31'd0, u_if.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_val", {16'd0, u_if.val_out}, 32'd0);
    chk("t6_rst_ov", {31'd0, u_if.out_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, u_if.busy}, 32'd0);
    chk("t6_rst_in_ready", {31'd0, u_if.in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_window(0, 1'b0, 1'b1, 9, 0);

    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
